// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Load/store type codes, field widths, FSM state encoding and the misalignment rule.
package mem_access_unit_pkg;

  localparam int LD_TYPE_WIDTH = 3;
  localparam int ST_TYPE_WIDTH = 2;

  localparam logic [LD_TYPE_WIDTH-1:0] LD_NONE = 3'd0;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LB   = 3'd1;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LH   = 3'd2;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LW   = 3'd3;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LBU  = 3'd4;
  localparam logic [LD_TYPE_WIDTH-1:0] LD_LHU  = 3'd5;

  localparam logic [ST_TYPE_WIDTH-1:0] ST_NONE = 2'd0;
  localparam logic [ST_TYPE_WIDTH-1:0] ST_SB   = 2'd1;
  localparam logic [ST_TYPE_WIDTH-1:0] ST_SH   = 2'd2;
  localparam logic [ST_TYPE_WIDTH-1:0] ST_SW   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic is_misaligned(input logic [LD_TYPE_WIDTH-1:0] ld,
                                         input logic [ST_TYPE_WIDTH-1:0] st,
                                         input logic [1:0] a);
    if (ld == LD_LH || ld == LD_LHU || st == ST_SH) return a[0];
    if (ld == LD_LW || st == ST_SW) return |a;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load-data extraction: shifts the read word down to its lane
// and sign- or zero-extends according to the load type.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0]              word,
  input  logic [1:0]               lane,
  input  logic [LD_TYPE_WIDTH-1:0] ld_type,
  output logic [31:0]              result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    result  = '0;
    case (ld_type)
      LD_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      LD_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      LD_LW:   result = shifted;
      LD_LBU:  result = {24'd0, shifted[7:0]};
      LD_LHU:  result = {16'd0, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: single-outstanding req/gnt/rvalid bus master.
// Optional misalignment trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LD_TYPE_WIDTH-1:0] op_ld_type,
  input  logic [ST_TYPE_WIDTH-1:0] op_st_type,
  input  logic [ADDR_WIDTH-1:0]    op_addr,
  input  logic [31:0]              op_wdata,
  input  logic                     kill,
  output logic                     mem_stall,
  output logic                     mem_valid,
  output logic [31:0]              mem_rdata,
  output logic                     mis_err,
  output logic [ADDR_WIDTH-1:0]    mis_addr,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDR_WIDTH-1:0]    dmem_addr,
  output logic [3:0]               dmem_wstrb,
  output logic [31:0]              dmem_wdata,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [31:0]              dmem_rdata
);

  function automatic logic [1:0] eff_lane(input logic [LD_TYPE_WIDTH-1:0] ld,
                                          input logic [ST_TYPE_WIDTH-1:0] st,
                                          input logic [1:0] a);
    if (ld == LD_LB || ld == LD_LBU || st == ST_SB) return a;
    if (ld == LD_LH || ld == LD_LHU || st == ST_SH) return {a[1], 1'b0};
    return 2'b00;
  endfunction

  function automatic logic [3:0] store_strb(input logic [ST_TYPE_WIDTH-1:0] st,
                                            input logic [1:0] lane);
    case (st)
      ST_SB:   return 4'b0001 << lane;
      ST_SH:   return 4'b0011 << lane;
      ST_SW:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [ST_TYPE_WIDTH-1:0] st,
                                             input logic [31:0] wd);
    case (st)
      ST_SB:   return {4{wd[7:0]}};
      ST_SH:   return {2{wd[15:0]}};
      ST_SW:   return wd;
      default: return 32'd0;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic [LD_TYPE_WIDTH-1:0] ld_q;
  logic [1:0]               lane_q;
  logic                     kill_q;
  logic [31:0]              rdata_q;
  logic [31:0]              ld_result;
  logic                     op_present;
  logic [ST_TYPE_WIDTH-1:0] eff_st;
  logic [1:0]               lane_in;
  logic                     mis_in;

  // A load wins if both fields are ever set together.
  assign op_present = (op_ld_type != LD_NONE) || (op_st_type != ST_NONE);
  assign eff_st     = (op_ld_type != LD_NONE) ? ST_NONE : op_st_type;
  assign lane_in    = eff_lane(op_ld_type, eff_st, op_addr[1:0]);

`ifdef MISALIGN_TRAP_EN
  logic                  mis_q;
  logic [ADDR_WIDTH-1:0] mis_addr_q;
  assign mis_in   = is_misaligned(op_ld_type, eff_st, op_addr[1:0]);
  assign mis_err  = mem_valid && mis_q;
  assign mis_addr = mis_addr_q;
`else
  assign mis_in   = 1'b0;
  assign mis_err  = 1'b0;
  assign mis_addr = '0;
`endif

  load_align u_load_align (
    .word    (dmem_rdata),
    .lane    (lane_q),
    .ld_type (ld_q),
    .result  (ld_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (op_present) state_d = mis_in ? S_DONE : S_REQ;
      S_REQ: begin
        if (dmem_gnt)  state_d = S_WAIT;
        else if (kill) state_d = S_IDLE;
      end
      S_WAIT: if (dmem_rvalid) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // DONE never stalls so the held op can retire without being reissued.
  assign mem_stall = (state_q != S_DONE) && ((state_q != S_IDLE) || op_present);
  assign mem_valid = (state_q == S_DONE) && !kill_q;
  assign dmem_req  = (state_q == S_REQ);
  assign mem_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ld_q       <= LD_NONE;
      lane_q     <= 2'b00;
      kill_q     <= 1'b0;
      rdata_q    <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (op_present) begin
          ld_q       <= op_ld_type;
          lane_q     <= lane_in;
          kill_q     <= 1'b0;
          rdata_q    <= '0;
          dmem_we    <= (op_ld_type == LD_NONE);
          dmem_addr  <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
          dmem_wstrb <= store_strb(eff_st, lane_in);
          dmem_wdata <= store_data(eff_st, op_wdata);
`ifdef MISALIGN_TRAP_EN
          mis_q      <= mis_in;
          mis_addr_q <= mis_in ? op_addr : '0;
`endif
        end
        S_REQ: if (kill) kill_q <= 1'b1;
        S_WAIT: begin
          if (kill) kill_q <= 1'b1;
          if (dmem_rvalid) rdata_q <= (ld_q != LD_NONE) ? ld_result : 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops push expected completions,
// a monitor pops and compares on every mem_valid; a bus responder models the memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  op_ld_type = '0;
  logic [1:0]  op_st_type = '0;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic        kill = 1'b0;
  logic        mem_stall, mem_valid, mis_err;
  logic [31:0] mem_rdata, mis_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_ld_type(op_ld_type), .op_st_type(op_st_type),
    .op_addr(op_addr), .op_wdata(op_wdata), .kill(kill),
    .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .mis_err(mis_err), .mis_addr(mis_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int valid_seen = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] maddr;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic [31:0] rd_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mem_valid) begin
        valid_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", mem_rdata, e.rdata);
          chk("mis_err", {31'd0, mis_err}, {31'd0, e.mis});
          chk("mis_addr", mis_addr, e.maddr);
          chk("valid_cycle", cyc, e.cyc);
        end
      end else if (rst_n && mis_err) begin
        chk("mis_err_without_valid", 32'd1, 32'd0);
      end
    end
  end

  // Memory responder: grant after gnt_dly request cycles, respond rv_dly cycles later.
  initial begin
    int gcnt;
    int rcnt;
    bit pend;
    gcnt = 0; rcnt = 0; pend = 0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (!rst_n) begin
        gcnt = 0; pend = 0;
      end else if (pend) begin
        if (rcnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = rd_word;
          pend = 0;
        end else rcnt--;
      end else if (dmem_req) begin
        if (gcnt >= gnt_dly) begin
          dmem_gnt = 1'b1;
          gcnt = 0;
          pend = 1;
          rcnt = rv_dly;
        end else gcnt++;
      end else gcnt = 0;
    end
  end

  // Issue one op from a negedge, hold it while stalled, check stall length and bus.
  task automatic do_op(input string nm, input logic [2:0] ld, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                       input int gd, input int rd, input logic [31:0] exp_rd, input logic exp_mis,
                       input logic [3:0] e_strb, input logic [31:0] e_wd);
    exp_t e;
    int   stalls, edges;
    bit   prev, seen, done;
    gnt_dly = gd; rv_dly = rd; rd_word = word;
    e.rdata = exp_rd;
    e.mis   = exp_mis;
    e.maddr = exp_mis ? addr : 32'd0;
    e.cyc   = exp_mis ? cyc + 1 : cyc + 3 + gd + rd;
    exp_q.push_back(e);
    op_ld_type = ld; op_st_type = st; op_addr = addr; op_wdata = wd;
    stalls = 0; edges = 0; prev = 0; seen = 0; done = 0;
    #1;
    for (int k = 0; k < 60; k++) begin
      if (dmem_req && !prev) edges++;
      if (dmem_req && !seen) begin
        seen = 1;
        chk({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({nm, "_we"}, {31'd0, dmem_we}, {31'd0, (ld == LD_NONE)});
        chk({nm, "_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, e_strb});
        chk({nm, "_wdata"}, dmem_wdata, e_wd);
      end
      prev = dmem_req;
      if (!mem_stall) begin
        done = 1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
    op_ld_type = '0; op_st_type = '0;
    chk({nm, "_stall_cycles"}, stalls, exp_mis ? 1 : 3 + gd + rd);
    chk({nm, "_req_count"}, edges, exp_mis ? 0 : 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int vs;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_mis_err", {31'd0, mis_err}, 32'd0);
    chk("rst_mis_addr", mis_addr, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_daddr", dmem_addr, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("lw",  LD_LW,  ST_NONE, 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 4'h0, 0);
    do_op("lb",  LD_LB,  ST_NONE, 32'h103, 0, 32'h80123456, 0, 0, 32'hFFFFFF80, 0, 4'h0, 0);
    do_op("lbu", LD_LBU, ST_NONE, 32'h103, 0, 32'h80123456, 0, 0, 32'h00000080, 0, 4'h0, 0);
    do_op("lh",  LD_LH,  ST_NONE, 32'h102, 0, 32'h80011234, 0, 0, 32'hFFFF8001, 0, 4'h0, 0);
    do_op("lhu", LD_LHU, ST_NONE, 32'h100, 0, 32'h1234F00D, 0, 0, 32'h0000F00D, 0, 4'h0, 0);
    do_op("lbp", LD_LB,  ST_NONE, 32'h101, 0, 32'h00007F00, 0, 0, 32'h0000007F, 0, 4'h0, 0);
    do_op("sb",  LD_NONE, ST_SB, 32'h201, 32'h000000AB, 32'h0, 0, 0, 0, 0, 4'b0010, 32'hABABABAB);
    do_op("sh",  LD_NONE, ST_SH, 32'h202, 32'h0000CDEF, 32'h0, 0, 0, 0, 0, 4'b1100, 32'hCDEFCDEF);
    do_op("sw",  LD_NONE, ST_SW, 32'h204, 32'h12345678, 32'h0, 0, 0, 0, 0, 4'hF, 32'h12345678);
    do_op("lw_slow", LD_LW, ST_NONE, 32'h108, 0, 32'hCAFEF00D, 3, 2, 32'hCAFEF00D, 0, 4'h0, 0);
`ifdef MISALIGN_TRAP_EN
    do_op("lw_mis", LD_LW, ST_NONE, 32'h102, 0, 32'h11223344, 0, 0, 32'h0, 1, 4'h0, 0);
    do_op("sh_mis", LD_NONE, ST_SH, 32'h203, 32'h5555, 32'h0, 0, 0, 32'h0, 1, 4'h0, 0);
`else
    do_op("lw_mis", LD_LW, ST_NONE, 32'h102, 0, 32'h11223344, 0, 0, 32'h11223344, 0, 4'h0, 0);
`endif

    // Kill while the request is still waiting for a grant.
    vs = valid_seen;
    gnt_dly = 20;
    op_ld_type = LD_LW; op_addr = 32'h300;
    @(negedge clk);
    chk("kreq_req_up", {31'd0, dmem_req}, 32'd1);
    kill = 1'b1; op_ld_type = '0;
    @(negedge clk);
    kill = 1'b0;
    chk("kreq_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("kreq_stall", {31'd0, mem_stall}, 32'd0);
    repeat (3) @(negedge clk);
    chk("kreq_no_valid", valid_seen, vs);

    // Kill while waiting for the response: runs to completion silently.
    gnt_dly = 0; rv_dly = 2;
    op_ld_type = LD_LW; op_addr = 32'h304;
    @(negedge clk);
    @(negedge clk);
    chk("kwait_in_wait", {31'd0, mem_stall && !dmem_req}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    for (int k = 0; k < 20 && mem_stall; k++) @(negedge clk);
    chk("kwait_stall_released", {31'd0, mem_stall}, 32'd0);
    op_ld_type = '0;
    repeat (3) @(negedge clk);
    chk("kwait_no_valid", valid_seen, vs);

    do_op("lw_after", LD_LW, ST_NONE, 32'h10C, 0, 32'h0BADC0DE, 1, 0, 32'h0BADC0DE, 0, 4'h0, 0);
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit of the MEM stage. It consumes the registered load/store operation held in the EX/MEM pipeline register, drives a single-outstanding request/response data-memory bus, and aligns and extends load data. It asserts `mem_stall` to freeze the pipeline while an access is in flight, and optionally flags misaligned accesses.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte-address width; data width is fixed at 32.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `op_ld_type`  in  `LD_TYPE_WIDTH`  load type from EX/MEM: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- `op_st_type`  in  `ST_TYPE_WIDTH`  store type: 0 none, 1 SB, 2 SH, 3 SW.
- `op_addr`  in  `ADDR_WIDTH`  byte address.
- `op_wdata`  in  32  store data, right-aligned.
- `kill`  in  1  abandon the current operation's result.
- `mem_stall`  out  1  hold upstream stages.
- `mem_valid`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  extended load result; 0 for stores.
- `mis_err`  out  1  misaligned-access pulse, coincident with `mem_valid`.
- `mis_addr`  out  `ADDR_WIDTH`  offending address.
- `dmem_req`  out  1  request, held until granted.
- `dmem_we`  out  1  1 for store.
- `dmem_addr`  out  `ADDR_WIDTH`  word address, low 2 bits 0.
- `dmem_wstrb`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  response or write-ack; earliest 1 cycle after grant.
- `dmem_rdata`  in  32  read word.

## Operation
- Operation is present when `op_ld_type` or `op_st_type` is nonzero. Both nonzero never occurs; if it does, the load takes priority.
- FSM states:
  - IDLE: when an op is present, latch type, addr and wdata. Go to REQ, or to DONE if the access is misaligned and the macro is enabled.
  - REQ: `dmem_req`=1. On `dmem_gnt`, go to WAIT.
  - WAIT: on `dmem_rvalid`, capture and go to DONE.
  - DONE: pulse outputs, then go to IDLE. Inputs are ignored in DONE, so a stalled, still-held op is never reissued.
- Store lane generation (lane = `addr[1:0]`):
  - SB: wdata `{4{b}}`, wstrb `4'b0001<<lane`.
  - SH: wdata `{2{h}}`, wstrb `4'b0011<<{addr[1],1'b0}`.
  - SW: wdata as-is, wstrb `4'hF`.
  - Loads: wstrb 0.
- Load extraction: shift `dmem_rdata` right by `8*lane`, then:
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: unchanged.
- `mem_stall` = (state != DONE) && (state != IDLE || op present).
- `kill` handling:
  - In REQ without `dmem_gnt`: drop the request and go to IDLE, with no `mem_valid`.
  - In REQ with `dmem_gnt`, or in WAIT: run to completion, but suppress `mem_valid` and `mis_err` in DONE.
  - In IDLE or DONE: no effect.

## Timing
- Reset: state IDLE. All outputs are 0, including `mem_rdata`, `mis_addr` and `dmem_*`.
- Aligned access, op first present in cycle N, zero-wait bus:
  - N: `mem_stall`=1.
  - N+1: REQ, `dmem_req`=1, `dmem_gnt`=1.
  - N+2: WAIT, `dmem_rvalid`=1.
  - N+3: DONE, `mem_valid`=1, `mem_stall`=0.
  - Minimum 4 cycles per access; each grant or response wait cycle adds one cycle.
- Misaligned access with the macro enabled: N stall, N+1 DONE. No bus activity.
- `dmem_addr`, `dmem_we`, `dmem_wstrb` and `dmem_wdata` are registered and stable from REQ until grant.
- A reset mid-operation returns to IDLE immediately. A pending response is dropped; the memory side is reset together with this block.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0, is misaligned.
  - Misaligned ops skip the bus and complete with `mis_err`=1, `mis_addr`=the address, and `mem_rdata`=0.
- Undefined:
  - No misalignment check. Halfword/word accesses use the address with low 1/2 bits cleared for lane selection.
  - `mis_err` and `mis_addr` are tied 0.

## Structure
- Shared header holds `LD_TYPE_WIDTH`, `ST_TYPE_WIDTH`, the load/store type codes and the FSM state codes.
- One sub-module, `load_align`: combinational extraction and extension of load data from word, lane and type.

## Test plan
- LW addr 0x100, `dmem_rdata` 0xDEADBEEF, zero-wait bus -> `mem_valid` at N+3, `mem_rdata`=0xDEADBEEF, stall high N..N+2.
- LB addr 0x103, rdata 0x80xxxxxx -> `mem_rdata`=0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr 0x102, rdata 0x8001xxxx -> 0xFFFF8001.
- SB addr 0x201, wdata 0x000000AB -> `dmem_we`=1, `dmem_wstrb`=0010, `dmem_wdata`=0xABABABAB, `dmem_addr`=0x200.
- `dmem_gnt` delayed 3 cycles and `dmem_rvalid` delayed 2 -> `dmem_req` held until grant, `mem_valid` at N+8, single request only.
- `kill` in REQ before grant -> `dmem_req` drops next cycle, no `mem_valid`. `kill` in WAIT -> response consumed, `mem_valid` stays 0.
- `MISALIGN_TRAP_EN`: LW addr 0x102 -> no `dmem_req`, N+1 `mem_valid`=1, `mis_err`=1, `mis_addr`=0x102. Without the macro, the same op reads word 0x100.
